// File: rtl/regarb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regarb_pkg;

    localparam int REGARB_DATA_W = 32;
    localparam int REGARB_ADDR_W = 5;
    localparam int STARVE_CNT_W  = 4;

    typedef enum logic [0:0] {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                     valid;
        logic [REGARB_ADDR_W-1:0] rd;
        logic [REGARB_DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] value,
        input logic [STARVE_CNT_W-1:0] limit
    );
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/regarb_scoreboard.sv
// Per-register reservation mask: set by a reserve request, cleared by the matching
// port-1 write; a same-cycle set and clear of one register leaves the bit set.
module regarb_scoreboard
    import regarb_pkg::*;
#(
    parameter int ADDR_W = REGARB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_rd,
    output logic [31:0]       mask
);

    // Register 0 is never reserved, so its bit is a constant.
    assign mask[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_bit
            logic set_hit;
            logic clr_hit;
            logic bit_reg;

            assign set_hit = set_valid && (set_rd == ADDR_W'(gi));
            assign clr_hit = clr_valid && (clr_rd == ADDR_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    bit_reg <= 1'b0;
                end else begin
                    bit_reg <= set_hit | (bit_reg & ~clr_hit);
                end
            end

            assign mask[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port arbiter for the register-file write port: port 0 has priority, a starve
// counter forces port 1 through. Define REGARB_SCOREBOARD_EN to build the busy_mask scoreboard.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_W       = REGARB_DATA_W,
    parameter int ADDR_W       = REGARB_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic [ADDR_W-1:0] p0_rd,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [ADDR_W-1:0] p1_rd,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Write_Data,
    output logic [31:0]       busy_mask,
    output logic              forced
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              state_reg;
    arb_state_t              state_next;
    logic [STARVE_CNT_W-1:0] cnt_reg;
    logic [STARVE_CNT_W-1:0] cnt_next;
    logic                    p0_fire;
    logic                    p1_fire;
    req_t                    grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_NORM;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Entering S_FORCE on the edge where the counter reaches the limit gives
    // port 1 the (limit+1)-th contended cycle.
    always_comb begin
        cnt_next = '0;
        if (p1_valid && !p1_ready) begin
            cnt_next = sat_inc(cnt_reg, LIMIT);
        end
        state_next = state_reg;
        case (state_reg)
            S_NORM:  if (cnt_next >= LIMIT) state_next = S_FORCE;
            S_FORCE: if (p1_fire || !p1_valid) state_next = S_NORM;
            default: state_next = S_NORM;
        endcase
    end

    always_comb begin
        p0_ready = 1'b1;
        p1_ready = !p0_valid;
        forced   = 1'b0;
        if (state_reg == S_FORCE) begin
            p1_ready = 1'b1;
            p0_ready = !p1_valid;
            forced   = 1'b1;
        end
    end

    assign p0_fire = p0_valid && p0_ready;
    assign p1_fire = p1_valid && p1_ready;

    always_comb begin
        grant = '0;
        if (p1_fire) begin
            grant.valid = 1'b1;
            grant.rd    = p1_rd;
            grant.data  = p1_data;
        end else if (p0_fire) begin
            grant.valid = 1'b1;
            grant.rd    = p0_rd;
            grant.data  = p0_data;
        end
    end

    // Writes to register 0 still complete the handshake but never enable the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite   <= 1'b0;
            Rd         <= '0;
            Write_Data <= '0;
        end else begin
            RegWrite <= grant.valid && (grant.rd != '0);
            if (grant.valid) begin
                Rd         <= grant.rd;
                Write_Data <= grant.data;
            end
        end
    end

`ifdef REGARB_SCOREBOARD_EN
    regarb_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (rsv_valid),
        .set_rd    (rsv_rd),
        .clr_valid (p1_fire),
        .clr_rd    (p1_rd),
        .mask      (busy_mask)
    );
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_rd};
    assign busy_mask  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter (STARVE_LIMIT = 4).
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p1_valid, rsv_valid;
    logic [4:0]  p0_rd, p1_rd, rsv_rd;
    logic [31:0] p0_data, p1_data;
    logic        p0_ready, p1_ready, RegWrite, forced;
    logic [4:0]  Rd;
    logic [31:0] Write_Data, busy_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .RegWrite(RegWrite), .Rd(Rd), .Write_Data(Write_Data),
        .busy_mask(busy_mask), .forced(forced)
    );

    typedef struct packed {
        logic        p0v;
        logic [4:0]  p0rd;
        logic [31:0] p0d;
        logic        p1v;
        logic [4:0]  p1rd;
        logic [31:0] p1d;
        logic        rv;
        logic [4:0]  rrd;
        logic        e_p0r;
        logic        e_p1r;
        logic        e_f;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic p0v, input logic [4:0] p0rd, input logic [31:0] p0d,
        input logic p1v, input logic [4:0] p1rd, input logic [31:0] p1d,
        input logic rv, input logic [4:0] rrd,
        input logic e_p0r, input logic e_p1r, input logic e_f,
        input logic e_rw, input logic [4:0] e_rd, input logic [31:0] e_wd,
        input logic [31:0] e_mask
    );
        vec_t v;
        v.p0v = p0v; v.p0rd = p0rd; v.p0d = p0d;
        v.p1v = p1v; v.p1rd = p1rd; v.p1d = p1d;
        v.rv = rv; v.rrd = rrd;
        v.e_p0r = e_p0r; v.e_p1r = e_p1r; v.e_f = e_f;
        v.e_rw = e_rw; v.e_rd = e_rd; v.e_wd = e_wd; v.e_mask = e_mask;
        return v;
    endfunction

    function automatic logic [31:0] mask_exp(input logic [31:0] m);
`ifdef REGARB_SCOREBOARD_EN
        return m;
`else
        return (m & 32'h0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        p0_valid = v.p0v; p0_rd = v.p0rd; p0_data = v.p0d;
        p1_valid = v.p1v; p1_rd = v.p1rd; p1_data = v.p1d;
        rsv_valid = v.rv; rsv_rd = v.rrd;
    endtask

    // Called at posedge+1: drive, check readies mid-cycle, check write port after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        @(negedge clk);
        chk({tag, "_p0_ready"}, {31'b0, p0_ready}, {31'b0, v.e_p0r});
        chk({tag, "_p1_ready"}, {31'b0, p1_ready}, {31'b0, v.e_p1r});
        chk({tag, "_forced"}, {31'b0, forced}, {31'b0, v.e_f});
        @(posedge clk);
        #1;
        chk({tag, "_RegWrite"}, {31'b0, RegWrite}, {31'b0, v.e_rw});
        chk({tag, "_Rd"}, {27'b0, Rd}, {27'b0, v.e_rd});
        chk({tag, "_Write_Data"}, Write_Data, v.e_wd);
        chk({tag, "_busy_mask"}, busy_mask, mask_exp(v.e_mask));
        $display("%s: p0v=%b p1v=%b rsv=%b -> RegWrite=%b Rd=%0d Write_Data=%h busy_mask=%h",
                 tag, v.p0v, v.p1v, v.rv, RegWrite, Rd, Write_Data, busy_mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        // Single-port traffic, rd 0 suppression, reservations and set-wins.
        vecs.push_back(mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h1234, 0, 0, 1, 1, 0, 0, 0, 32'h1234, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 32'h1234, 32'h80));
        vecs.push_back(mk(0, 0, 0, 1, 9, 32'h99, 0, 0, 1, 1, 0, 1, 9, 32'h99, 32'h80));
        vecs.push_back(mk(0, 0, 0, 1, 7, 32'h77, 0, 0, 1, 1, 0, 1, 7, 32'h77, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 7, 32'h77, 32'h80));
        vecs.push_back(mk(0, 0, 0, 1, 7, 32'h70, 1, 7, 1, 1, 0, 1, 7, 32'h70, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 7, 32'h70, 32'h80));
        vecs.push_back(mk(1, 7, 32'h5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 7, 32'h5, 32'h80));
        vecs.push_back(mk(0, 0, 0, 1, 7, 32'h6, 0, 0, 1, 1, 0, 1, 7, 32'h6, 32'h0));
        // Port 1 alone: always ready, never forced.
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 0, 0, 1, 10, 32'hA0 + i, 0, 0, 1, 1, 0, 1, 10, 32'hA0 + i, 0));
        end
        // Continuous contention: port 1 wins every 5th cycle.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                vecs.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 1, 0, 0, 1, 1, 32'hA1, 0));
            end
            if (r < 2) begin
                vecs.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 1, 1, 1, 2, 32'hB2, 0));
            end
        end
        // Forced cycle where port 1 has withdrawn: port 0 goes through, then back to normal.
        vecs.push_back(mk(1, 1, 32'hA1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 32'hA1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA1, 0));

        reset = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_RegWrite", {31'b0, RegWrite}, 32'h0);
        chk("rst_Rd", {27'b0, Rd}, 32'h0);
        chk("rst_Write_Data", Write_Data, 32'h0);
        chk("rst_busy_mask", busy_mask, 32'h0);
        chk("rst_forced", {31'b0, forced}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted mid-traffic while forced and with a reservation held.
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 1, 32'hA1, 32'h10), "pre_rsv");
        for (int i = 0; i < 4; i++) begin
            run_vec(mk(1, 3, 32'h33, 1, 12, 32'hCC, 0, 0, 1, 0, 0, 1, 3, 32'h33, 32'h10),
                    $sformatf("pre_c%0d", i));
        end
        chk("pre_forced", {31'b0, forced}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_RegWrite", {31'b0, RegWrite}, 32'h0);
        chk("mid_Rd", {27'b0, Rd}, 32'h0);
        chk("mid_Write_Data", Write_Data, 32'h0);
        chk("mid_busy_mask", busy_mask, 32'h0);
        chk("mid_forced", {31'b0, forced}, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_drop_RegWrite", {31'b0, RegWrite}, 32'h0);
        chk("mid_drop_Rd", {27'b0, Rd}, 32'h0);
        $display("reset_mid: RegWrite=%b Rd=%0d busy_mask=%h forced=%b", RegWrite, Rd, busy_mask, forced);
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_idle%0d_RegWrite", i), {31'b0, RegWrite}, 32'h0);
        end
        run_vec(mk(1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 1, 0, 0, 1, 5, 32'h55, 0), "post_fire");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
